// File: rtl/spi_regfile_receiver.sv
// SPI slave: NUM_REGS x DATA_W register bank with MISO readback plus a bit-stream channel.
// Define SPI_REGFILE_AUTOINC_EN for burst writes/reads with address auto-increment.
module spi_regfile_receiver #(
  parameter int unsigned                NUM_REGS     = 8,
  parameter int unsigned                DATA_W       = 8,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALUES = '0,
  parameter logic [6:0]                 STREAM_ADDR  = 7'h7F,
  parameter int unsigned                SYNC_STAGES  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         spi_sclk,
  input  logic                         spi_mosi,
  input  logic                         spi_cs,
  output logic                         spi_miso,
  input  logic                         stream_in,
  output logic                         stream_shift,
  output logic                         stream_bit,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic                         wr_strobe,
  output logic [6:0]                   wr_addr,
  output logic                         busy
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_STREAM} state_t;

  logic [SYNC_STAGES-1:0] sclk_q, mosi_q, cs_q;
  logic                   sclk_dly_q;
  logic                   sclk_sync, mosi_sync, cs_sync;
  logic                   sample, drive;

  // cs chain resets to "selected" so a frame already in progress at reset release is not joined.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q     <= '0;
      mosi_q     <= '0;
      cs_q       <= '0;
      sclk_dly_q <= 1'b0;
    end else begin
      sclk_q     <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_q     <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      cs_q       <= {cs_q[SYNC_STAGES-2:0], spi_cs};
      sclk_dly_q <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign sclk_sync = sclk_q[SYNC_STAGES-1];
  assign mosi_sync = mosi_q[SYNC_STAGES-1];
  assign cs_sync   = cs_q[SYNC_STAGES-1];
  assign sample    = sclk_dly_q & ~sclk_sync & ~cs_sync;
  assign drive     = ~sclk_dly_q & sclk_sync & ~cs_sync;

  state_t                       state_q;
  logic                         armed_q;
  logic [6:0]                   cmd_q;
  logic [6:0]                   addr_q;
  logic                         wr_q;
  logic [5:0]                   cnt_q;
  logic [DATA_W-1:0]            hold_q;
  logic [DATA_W-1:0]            miso_sh_q;
  logic                         miso_q;
  logic [NUM_REGS*DATA_W-1:0]   regs_q;
  logic                         wr_strobe_q;
  logic [6:0]                   wr_addr_q;
  logic                         stream_shift_q;
  logic                         stream_bit_q;

  logic [6:0]        cmd_addr;
  logic [DATA_W-1:0] word_next;
  logic [DATA_W-1:0] cmd_rd;
  logic              addr_in_range;

  assign cmd_addr      = {cmd_q[5:0], mosi_sync};
  assign word_next     = (hold_q << 1) | DATA_W'(mosi_sync);
  assign addr_in_range = 32'(addr_q) < NUM_REGS;

`ifdef SPI_REGFILE_AUTOINC_EN
  logic [6:0]        inc_addr;
  logic [DATA_W-1:0] inc_rd;
  assign inc_addr = (32'(addr_q) == NUM_REGS - 1) ? '0 : addr_q + 7'd1;

  always_comb begin
    inc_rd = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (32'(inc_addr) == i) inc_rd = regs_q[i*DATA_W +: DATA_W];
  end
`endif

  always_comb begin
    cmd_rd = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (32'(cmd_addr) == i) cmd_rd = regs_q[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      armed_q        <= 1'b0;
      cmd_q          <= '0;
      addr_q         <= '0;
      wr_q           <= 1'b0;
      cnt_q          <= '0;
      hold_q         <= '0;
      miso_sh_q      <= '0;
      miso_q         <= 1'b0;
      regs_q         <= RESET_VALUES;
      wr_strobe_q    <= 1'b0;
      wr_addr_q      <= '0;
      stream_shift_q <= 1'b0;
      stream_bit_q   <= 1'b0;
    end else begin
      wr_strobe_q    <= 1'b0;
      stream_shift_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A frame starts only after cs has been seen high at least once.
          if (cs_sync) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            armed_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_CMD;
          end
        end
        S_CMD: begin
          if (cs_sync) begin
            state_q <= S_IDLE;
          end else if (sample) begin
            if (cnt_q == 6'd7) begin
              cnt_q  <= '0;
              addr_q <= cmd_addr;
              wr_q   <= cmd_q[6];
              if (cmd_addr == STREAM_ADDR) begin
                state_q <= S_STREAM;
              end else begin
                miso_sh_q <= cmd_rd;
                state_q   <= S_DATA;
              end
            end else begin
              cmd_q <= {cmd_q[5:0], mosi_sync};
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        S_DATA: begin
          if (cs_sync) begin
            state_q <= S_IDLE;
          end else begin
            if (drive) begin
              miso_q    <= miso_sh_q[DATA_W-1];
              miso_sh_q <= miso_sh_q << 1;
            end
            if (sample) begin
              if (32'(cnt_q) == DATA_W - 1) begin
                cnt_q <= '0;
                if (wr_q && addr_in_range) begin
                  for (int unsigned i = 0; i < NUM_REGS; i++)
                    if (32'(addr_q) == i) regs_q[i*DATA_W +: DATA_W] <= word_next;
                  wr_strobe_q <= 1'b1;
                  wr_addr_q   <= addr_q;
                end
`ifdef SPI_REGFILE_AUTOINC_EN
                addr_q    <= inc_addr;
                miso_sh_q <= inc_rd;
`else
                state_q   <= S_CMD;
`endif
              end else begin
                hold_q <= word_next;
                cnt_q  <= cnt_q + 6'd1;
              end
            end
          end
        end
        S_STREAM: begin
          if (cs_sync) begin
            state_q <= S_IDLE;
          end else begin
            if (drive) miso_q <= stream_in;
            if (sample) begin
              stream_shift_q <= 1'b1;
              stream_bit_q   <= mosi_sync;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign spi_miso     = miso_q;
  assign stream_shift = stream_shift_q;
  assign stream_bit   = stream_bit_q;
  assign regs         = regs_q;
  assign wr_strobe    = wr_strobe_q;
  assign wr_addr      = wr_addr_q;
  assign busy         = ~cs_sync;

endmodule

// File: tb/tb_spi_regfile_receiver.sv
// Directed bench for spi_regfile_receiver: table of single-word frames plus multi-cycle sequences.
module tb_spi_regfile_receiver;
  localparam int H = 8;
  localparam logic [63:0] RV = 64'h8776_6554_4332_2110;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sclk = 1'b0, mosi = 1'b0, cs = 1'b1, stream_in = 1'b0;
  logic miso, stream_shift, stream_bit, wr_strobe, busy;
  logic [63:0] regs;
  logic [6:0]  wr_addr;

  always #5 clk = ~clk;

  spi_regfile_receiver #(
    .NUM_REGS(8), .DATA_W(8), .RESET_VALUES(RV), .STREAM_ADDR(7'h7F), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs(cs),
    .spi_miso(miso), .stream_in(stream_in), .stream_shift(stream_shift),
    .stream_bit(stream_bit), .regs(regs), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .busy(busy)
  );

  int total = 0, bad = 0;
  int wr_cnt = 0, st_cnt = 0;
  logic [6:0] wr_log [0:15];
  logic       st_log [0:255];

  always @(negedge clk) begin
    if (wr_strobe) begin wr_log[wr_cnt % 16] = wr_addr; wr_cnt++; end
    if (stream_shift) begin st_log[st_cnt % 256] = stream_bit; st_cnt++; end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // MSB-first transfer of the low n bits; stream_in mirrors ~mosi for stream readback.
  task automatic xfer(input logic [31:0] d, input int n, output logic [31:0] r);
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      repeat (H/2) @(negedge clk);
      mosi = d[i];
      stream_in = ~d[i];
      repeat (H/2) @(negedge clk);
      sclk = 1'b1;
      repeat (H) @(negedge clk);
      r = {r[30:0], miso};
      sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (H) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] miso;
    int         ra;
    logic [7:0] rv;
    int         strobes;
  } vec_t;

  vec_t tbl [8];

  function automatic logic pat(input int i);
    return ((i % 3) == 0) ^ ((i % 7) == 2);
  endfunction

  initial begin
    logic [31:0] r;
    int base, err_bits, err_miso;

    tbl[0] = '{8'h83, 8'hA5, 8'h43, 3, 8'hA5, 1};
    tbl[1] = '{8'h02, 8'h00, 8'h32, 2, 8'h32, 0};
    tbl[2] = '{8'h03, 8'hFF, 8'hA5, 3, 8'hA5, 0};
    tbl[3] = '{8'h80, 8'h5A, 8'h10, 0, 8'h5A, 1};
    tbl[4] = '{8'h0A, 8'h00, 8'h00, 0, 8'h5A, 0};
    tbl[5] = '{8'h8A, 8'h33, 8'h00, 7, 8'h87, 0};
    tbl[6] = '{8'h87, 8'hC3, 8'h87, 7, 8'hC3, 1};
    tbl[7] = '{8'h00, 8'h00, 8'h5A, 0, 8'h5A, 0};

    repeat (3) @(negedge clk);
    check("regs_in_reset", regs, RV);
    check("miso_in_reset", {63'd0, miso}, 64'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("regs_after_reset", regs, RV);
    check("miso_after_reset", {63'd0, miso}, 64'd0);
    check("wr_addr_after_reset", {57'd0, wr_addr}, 64'd0);
    check("busy_idle", {63'd0, busy}, 64'd0);
    check("no_strobes_after_reset", 64'(wr_cnt + st_cnt), 64'd0);

    for (int v = 0; v < 8; v++) begin
      base = wr_cnt;
      cs_low();
      check($sformatf("busy_v%0d", v), {63'd0, busy}, 64'd1);
      xfer(32'(tbl[v].cmd), 8, r);
      xfer(32'(tbl[v].data), 8, r);
      cs_high();
      check($sformatf("miso_v%0d", v), 64'(r[7:0]), 64'(tbl[v].miso));
      check($sformatf("reg_v%0d", v), 64'(regs[tbl[v].ra*8 +: 8]), 64'(tbl[v].rv));
      check($sformatf("strobes_v%0d", v), 64'(wr_cnt - base), 64'(tbl[v].strobes));
      if (tbl[v].strobes == 1)
        check($sformatf("wr_addr_v%0d", v), 64'(wr_log[base % 16]), 64'(tbl[v].cmd[6:0]));
    end
    check("regs_after_table", regs, 64'hC376_6554_A532_215A);

    // Write aborted by cs after 5 data bits.
    base = wr_cnt;
    cs_low();
    xfer(32'h85, 8, r);
    xfer(32'h15, 5, r);
    cs_high();
    check("abort_reg5", 64'(regs[5*8 +: 8]), 64'h65);
    check("abort_strobes", 64'(wr_cnt - base), 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    cs_low();
    xfer(32'h05, 8, r);
    xfer(32'h00, 8, r);
    cs_high();
    check("abort_readback", 64'(r[7:0]), 64'h65);

    // Stream channel: 100 bits.
    base = st_cnt;
    err_miso = 0;
    cs_low();
    xfer(32'hFF, 8, r);
    for (int i = 0; i < 100; i++) begin
      xfer({31'd0, pat(i)}, 1, r);
      if (r[0] !== ~pat(i)) err_miso++;
    end
    cs_high();
    check("stream_count", 64'(st_cnt - base), 64'd100);
    err_bits = 0;
    for (int i = 0; i < 100; i++)
      if (st_log[(base + i) % 256] !== pat(i)) err_bits++;
    check("stream_bits", 64'(err_bits), 64'd0);
    check("stream_miso", 64'(err_miso), 64'd0);
    check("stream_regs", regs, 64'hC376_6554_A532_215A);

    // Three bytes in one frame.
    base = wr_cnt;
    cs_low();
    xfer(32'h87, 8, r);
    xfer(32'h11, 8, r);
    check("burst_miso0", 64'(r[7:0]), 64'hC3);
    xfer(32'h22, 8, r);
`ifdef SPI_REGFILE_AUTOINC_EN
    check("burst_miso1", 64'(r[7:0]), 64'h5A);
`endif
    cs_high();
    check("burst_reg7", 64'(regs[7*8 +: 8]), 64'h11);
    check("burst_addr0", 64'(wr_log[base % 16]), 64'd7);
`ifdef SPI_REGFILE_AUTOINC_EN
    check("burst_strobes", 64'(wr_cnt - base), 64'd2);
    check("burst_reg0", 64'(regs[7:0]), 64'h22);
    check("burst_addr1", 64'(wr_log[(base + 1) % 16]), 64'd0);
`else
    check("burst_strobes", 64'(wr_cnt - base), 64'd1);
    check("burst_reg0", 64'(regs[7:0]), 64'h5A);
`endif

    // Reset in mid-frame; frame must not resume until cs cycles.
    cs_low();
    xfer(32'h8, 4, r);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_regs", regs, RV);
    check("midreset_miso", {63'd0, miso}, 64'd0);
    reset = 1'b0;
    base = wr_cnt;
    xfer(32'h81, 8, r);
    xfer(32'hEE, 8, r);
    check("midreset_busy", {63'd0, busy}, 64'd1);
    check("midreset_miso_idle", {63'd0, miso}, 64'd0);
    cs_high();
    check("midreset_strobes", 64'(wr_cnt - base), 64'd0);
    check("midreset_reg1", 64'(regs[15:8]), 64'h21);
    cs_low();
    xfer(32'h81, 8, r);
    xfer(32'hEE, 8, r);
    cs_high();
    check("newframe_miso", 64'(r[7:0]), 64'h21);
    check("newframe_reg1", 64'(regs[15:8]), 64'hEE);
    check("newframe_strobes", 64'(wr_cnt - base), 64'd1);
    check("newframe_wr_addr", 64'(wr_log[base % 16]), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
